icache_ctrl: RTL and testbench
==============================

// Module: icache_ctrl
// PURPOSE
//  Direct-mapped, read-only instruction cache controller between the IF stage and a backing
//  word-wide memory port. Hits answer in the request cycle. A miss runs a line refill FSM.
//  The refill completes with the requested word forwarded (ready=1, hit=0).
//  flush_i (fence.i) invalidates every line.
// PARAMETERS
//  ADDR_W      12  word-address width of req_addr / mem_req_addr
//  LINE_WORDS  4   words per line (power of 2, >=2)
//  SETS        64  number of lines (power of 2); TAG_W = ADDR_W-log2(SETS)-log2(LINE_WORDS)
// PORTS
//  clk             in   1       clock
//  rst             in   1       asynchronous reset, active-high
//  req_addr        in   ADDR_W  fetch word address (PC[ADDR_W+1:2])
//  req_valid       in   1       fetch request
//  req_rw          in   1       0=read; 1=write (unsupported, ignored)
//  data_read       out  32      instruction word, valid when ready=1
//  ready           out  1       data_read valid this cycle
//  hit             out  1       1=served from array; 0 with ready=1 = refill forward
//  flush_i         in   1       invalidate all lines (one-cycle pulse)
//  busy_o          out  1       FSM not IDLE
//  mem_req_valid   out  1       backing read request
//  mem_req_addr    out  ADDR_W  backing word address
//  mem_req_ready   in   1       request accepted when valid&ready
//  mem_resp_valid  in   1       response beat
//  mem_resp_data   in   32      response word
// BEHAVIOUR
//  - Reset: all valid bits 0, state IDLE, mem_req_valid=0, busy_o=0; ready=hit=0, data_read=0.
//  - IDLE lookup is combinational: index/tag from req_addr.
//    On a hit (valid&tag match&req_valid&!req_rw): ready=1, hit=1, data_read=word, 0 cycles.
//  - Miss in IDLE: ready=0, hit=0. Latch req_addr in miss_addr, set beat=0, go to REFILL.
//  - REFILL issues LINE_WORDS single-word reads in order: word 0..LINE_WORDS-1 of miss_addr's line.
//    At most one outstanding request. mem_req_valid is held until mem_req_ready.
//    After acceptance, wait for mem_resp_valid before issuing the next request.
//  - Each response writes the data array. beat increments and wraps to 0 after the last beat.
//  - Last response cycle: write tag, set valid, return to IDLE.
//    If req_addr==miss_addr that cycle: ready=1, hit=0, data_read=the requested word.
//    For the requested word, use mem_resp_data if it is the last beat, else the array.
//    If req_addr differs (redirect): ready=0. The line is still installed.
//  - ready=0 in every other REFILL cycle. busy_o=1 throughout REFILL.
//  - flush_i in IDLE: all valid bits clear next cycle. No hit is reported in the flush cycle.
//  - flush_i during REFILL: the bus transaction still completes (cannot abort).
//    That line is NOT marked valid, all valid bits clear, and no forward is given (ready=0).
//  - req_rw=1 or req_valid=0: ready=0, hit=0, no state change.
//  - Async reset mid-REFILL: FSM returns to IDLE immediately; any late mem_resp_valid is ignored.
//  - Simultaneous mem_req_ready and mem_resp_valid for the same beat: not legal (resp follows req).
// CONFIGURATION
//  - ICACHE_STATS_EN defined: adds outputs stat_hits[31:0] and stat_misses[31:0], reset 0, wrapping.
//    stat_hits +1 each cycle with ready&hit. stat_misses +1 on each IDLE->REFILL transition.
//  - Undefined: those ports and counters do not exist. All other behaviour is identical.
// STRUCTURE
//  - icache_pkg: FSM state enum (IDLE, REFILL), localparams IDX_W, OFF_W, TAG_W,
//    and address-slice helper functions (tag/index/offset).
//  - Sub-module icache_line_store: tag+valid array, data array, one read port, one write port,
//    and a synchronous invalidate-all. icache_ctrl holds the FSM, miss latch and beat counter.
// TESTING
//  1 Cold miss: req_addr=0x010 after reset -> ready=0; mem reads 0x010..0x013 in order.
//    Last beat: ready=1, hit=0, data=word@0x010. Next cycle same addr: ready=1, hit=1.
//  2 Hit sweep: after 1, addrs 0x011..0x013 -> each ready=1, hit=1 the same cycle, correct data.
//  3 Conflict: 0x010 then 0x110 (same index, tag differs) -> refill. Then 0x010 misses again.
//  4 Backpressure: mem_req_ready held low 5 cycles, responses with 3-cycle latency.
//    -> mem_req_addr stable while stalled, one outstanding request, final forward correct.
//  5 Flush: flush_i pulse in IDLE -> a previously hitting addr misses.
//    flush_i mid-refill -> refill finishes, ready=0, the same addr misses again.
//  6 Redirect: req_addr changes to 0x020 during the 0x010 refill -> no forward.
//    0x010 line then hits; 0x020 refill starts after.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared geometry, FSM state type and address-slice helpers for the instruction cache.
package icache_pkg;
   localparam int ADDR_W     = 12;
   localparam int LINE_WORDS = 4;
   localparam int SETS       = 64;
   localparam int OFF_W      = $clog2(LINE_WORDS);
   localparam int IDX_W      = $clog2(SETS);
   localparam int TAG_W      = ADDR_W - IDX_W - OFF_W;

   typedef enum logic {IDLE, REFILL} state_t;

   function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
      return a[ADDR_W-1 -: TAG_W];
   endfunction

   function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
      return a[OFF_W +: IDX_W];
   endfunction

   function automatic logic [OFF_W-1:0] addr_off(input logic [ADDR_W-1:0] a);
      return a[OFF_W-1:0];
   endfunction
endpackage

// File: rtl/icache_line_store.sv
// Tag/valid and data arrays: combinational read port, one write port, synchronous invalidate-all.
// Only the valid bits are reset; tags and data are meaningless until a line is installed.
module icache_line_store
   import icache_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] rd_idx,
   input  logic [OFF_W-1:0] rd_off,
   output logic             rd_valid,
   output logic [TAG_W-1:0] rd_tag,
   output logic [31:0]      rd_data,
   input  logic             data_we,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [OFF_W-1:0] wr_off,
   input  logic [31:0]      wr_data,
   input  logic             tag_we,
   input  logic [TAG_W-1:0] wr_tag,
   input  logic             inv_all
);
   logic [SETS-1:0]  valid;
   logic [TAG_W-1:0] tag_mem  [SETS];
   logic [31:0]      data_mem [SETS*LINE_WORDS];

   assign rd_valid = valid[rd_idx];
   assign rd_tag   = tag_mem[rd_idx];
   assign rd_data  = data_mem[{rd_idx, rd_off}];

   // Invalidate wins over a same-cycle install.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         valid <= '0;
      else if (inv_all)
         valid <= '0;
      else if (tag_we)
         valid[wr_idx] <= 1'b1;
   end

   always_ff @(posedge clk) begin
      if (tag_we)
         tag_mem[wr_idx] <= wr_tag;
      if (data_we)
         data_mem[{wr_idx, wr_off}] <= wr_data;
   end
endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped read-only I-cache controller: same-cycle hits, single-outstanding line refill.
// ICACHE_STATS_EN adds stat_hits / stat_misses counters.
module icache_ctrl
   import icache_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic              req_valid,
   input  logic              req_rw,
   output logic [31:0]       data_read,
   output logic              ready,
   output logic              hit,
   input  logic              flush_i,
   output logic              busy_o,
   output logic              mem_req_valid,
   output logic [ADDR_W-1:0] mem_req_addr,
   input  logic              mem_req_ready,
   input  logic              mem_resp_valid,
   input  logic [31:0]       mem_resp_data
`ifdef ICACHE_STATS_EN
  ,output logic [31:0]       stat_hits,
   output logic [31:0]       stat_misses
`endif
);
   state_t            state, next_state;
   logic [ADDR_W-1:0] miss_addr;
   logic [OFF_W-1:0]  beat;
   logic              waiting;
   logic              flushed;

   logic              rd_valid;
   logic [TAG_W-1:0]  rd_tag;
   logic [31:0]       rd_data;
   logic              fetch, lookup_hit, resp_beat, last_beat, start_miss, tag_we;

   assign fetch         = req_valid && !req_rw;
   assign lookup_hit    = rd_valid && (rd_tag == addr_tag(req_addr));
   assign resp_beat     = (state == REFILL) && waiting && mem_resp_valid;
   assign last_beat     = resp_beat && (beat == OFF_W'(LINE_WORDS-1));
   assign tag_we        = last_beat && !flushed && !flush_i;
   assign busy_o        = (state == REFILL);
   assign mem_req_valid = (state == REFILL) && !waiting;
   assign mem_req_addr  = {miss_addr[ADDR_W-1:OFF_W], beat};

   icache_line_store u_store (
      .clk      (clk),
      .rst      (rst),
      .rd_idx   (addr_idx(req_addr)),
      .rd_off   (addr_off(req_addr)),
      .rd_valid (rd_valid),
      .rd_tag   (rd_tag),
      .rd_data  (rd_data),
      .data_we  (resp_beat),
      .wr_idx   (addr_idx(miss_addr)),
      .wr_off   (beat),
      .wr_data  (mem_resp_data),
      .tag_we   (tag_we),
      .wr_tag   (addr_tag(miss_addr)),
      .inv_all  (flush_i)
   );

   always_comb begin
      next_state = state;
      ready      = 1'b0;
      hit        = 1'b0;
      data_read  = '0;
      start_miss = 1'b0;
      case (state)
         IDLE: begin
            if (fetch && !flush_i) begin
               if (lookup_hit) begin
                  ready     = 1'b1;
                  hit       = 1'b1;
                  data_read = rd_data;
               end else begin
                  start_miss = 1'b1;
                  next_state = REFILL;
               end
            end
         end
         REFILL: begin
            if (last_beat) begin
               next_state = IDLE;
               // The final word is not in the array yet, so forward it straight from the bus.
               if (fetch && req_addr == miss_addr && !flushed && !flush_i) begin
                  ready     = 1'b1;
                  data_read = (addr_off(req_addr) == beat) ? mem_resp_data : rd_data;
               end
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         miss_addr <= '0;
         beat      <= '0;
         waiting   <= 1'b0;
         flushed   <= 1'b0;
      end else begin
         state <= next_state;
         if (start_miss) begin
            miss_addr <= req_addr;
            beat      <= '0;
            waiting   <= 1'b0;
            flushed   <= 1'b0;
         end else if (state == REFILL) begin
            if (mem_req_valid && mem_req_ready)
               waiting <= 1'b1;
            else if (resp_beat) begin
               waiting <= 1'b0;
               beat    <= beat + 1'b1;
            end
            if (flush_i)
               flushed <= 1'b1;
         end
      end
   end

`ifdef ICACHE_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_hits   <= '0;
         stat_misses <= '0;
      end else begin
         if (ready && hit)
            stat_hits <= stat_hits + 1'b1;
         if (start_miss)
            stat_misses <= stat_misses + 1'b1;
      end
   end
`endif
endmodule

// File: tb/tb_icache_ctrl.sv
// Bench for icache_ctrl: directed scenarios plus random fetches against a tag-table model
// and a word-addressed memory responder with configurable stall and latency.
module tb_icache_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [11:0] req_addr = '0;
   logic        req_valid = 1'b0;
   logic        req_rw = 1'b0;
   logic [31:0] data_read;
   logic        ready, hit;
   logic        flush_i = 1'b0;
   logic        busy_o;
   logic        mem_req_valid;
   logic [11:0] mem_req_addr;
   logic        mem_req_ready = 1'b0;
   logic        mem_resp_valid = 1'b0;
   logic [31:0] mem_resp_data = '0;
`ifdef ICACHE_STATS_EN
   logic [31:0] stat_hits, stat_misses;
`endif

   icache_ctrl dut (
      .clk(clk), .rst(rst), .req_addr(req_addr), .req_valid(req_valid), .req_rw(req_rw),
      .data_read(data_read), .ready(ready), .hit(hit), .flush_i(flush_i), .busy_o(busy_o),
      .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
`ifdef ICACHE_STATS_EN
     ,.stat_hits(stat_hits), .stat_misses(stat_misses)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Backing memory and reference cache state (set -> valid, tag)
   logic [31:0] mem [4096];
   bit          mvalid [64];
   logic [3:0]  mtag [64];

   function automatic bit model_hit(input logic [11:0] a);
      return mvalid[a[7:2]] && (mtag[a[7:2]] == a[11:8]);
   endfunction

   task automatic model_install(input logic [11:0] a);
      mvalid[a[7:2]] = 1'b1;
      mtag[a[7:2]]   = a[11:8];
   endtask

   task automatic model_clear();
      foreach (mvalid[i]) mvalid[i] = 1'b0;
   endtask

   // Memory responder: drives on the falling edge, DUT consumes on the rising edge.
   int          req_stall = 0;
   int          resp_lat  = 0;
   bit          pend = 1'b0;
   int          stall_cnt = 0, lat_cnt = 0;
   logic [11:0] pend_addr = '0;
   bit          prev_stalled = 1'b0;
   logic [11:0] prev_addr = '0;
   logic [11:0] issued [$];

   always @(negedge clk) begin
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      if (rst) begin
         prev_stalled = 1'b0;
         stall_cnt    = 0;
      end
      if (pend) begin
         check("one_outstanding", mem_req_valid, 1'b0);
         if (lat_cnt == 0) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = mem[pend_addr];
            pend           = 1'b0;
         end else
            lat_cnt--;
      end else if (mem_req_valid && !rst) begin
         if (prev_stalled) check("req_addr_stable", mem_req_addr, prev_addr);
         if (stall_cnt < req_stall) begin
            stall_cnt++;
            prev_stalled = 1'b1;
            prev_addr    = mem_req_addr;
         end else begin
            mem_req_ready = 1'b1;
            pend          = 1'b1;
            pend_addr     = mem_req_addr;
            lat_cnt       = resp_lat;
            stall_cnt     = 0;
            prev_stalled  = 1'b0;
            issued.push_back(mem_req_addr);
         end
      end else
         prev_stalled = 1'b0;
   end

   task automatic check_issued(input string tag, input logic [11:0] a);
      logic [11:0] base;
      base = {a[11:2], 2'b00};
      check({tag, "_nreq"}, issued.size(), 4);
      for (int i = 0; i < issued.size() && i < 4; i++)
         check({tag, "_req_order"}, issued[i], base + 12'(i));
   endtask

   // One fetch: hit in the request cycle, or a refill ending in a forward of the word.
   task automatic read_word(input logic [11:0] a, input string tag);
      bit exp_hit;
      int cyc;
      exp_hit = model_hit(a);
      issued.delete();
      @(negedge clk);
      req_valid = 1'b1; req_rw = 1'b0; req_addr = a;
      #4;
      check({tag, "_ready_first"}, ready, exp_hit);
      check({tag, "_hit_first"}, hit, exp_hit);
      if (exp_hit) begin
         check({tag, "_hit_data"}, data_read, mem[a]);
         return;
      end
      cyc = 0;
      do begin
         @(negedge clk); #4;
         cyc++;
         check({tag, "_busy"}, busy_o, 1'b1);
      end while (!ready && cyc < 200);
      check({tag, "_fwd_ready"}, ready, 1'b1);
      check({tag, "_fwd_hit"}, hit, 1'b0);
      check({tag, "_fwd_data"}, data_read, mem[a]);
      check_issued(tag, a);
      model_install(a);
   endtask

   // Follow an in-flight refill to its last response beat, expecting no forward at all.
   task automatic ride_refill(input string tag, input bit pulse_flush);
      int beats, cyc;
      beats = 0; cyc = 0;
      while (beats < 4 && cyc < 200) begin
         @(negedge clk);
         if (pulse_flush) flush_i = (cyc == 2);
         #4;
         cyc++;
         check({tag, "_no_fwd"}, ready, 1'b0);
         if (mem_resp_valid && busy_o) beats++;
      end
      check({tag, "_beats"}, beats, 4);
   endtask

   logic [11:0] ra;
   int          cyc;

   initial begin
      foreach (mem[i]) mem[i] = $urandom;
      model_clear();
      #1 rst = 1'b1;
      #2;
      check("rst_ready", ready, 1'b0);
      check("rst_hit", hit, 1'b0);
      check("rst_data", data_read, 32'h0);
      check("rst_busy", busy_o, 1'b0);
      check("rst_mem_req_valid", mem_req_valid, 1'b0);
      @(negedge clk); rst = 1'b0;

      // Cold miss, then hits over the same line
      read_word(12'h010, "cold");
      read_word(12'h010, "cold_rehit");
      read_word(12'h011, "sweep1");
      read_word(12'h012, "sweep2");
      read_word(12'h013, "sweep3");

      // Conflict on the same set
      read_word(12'h110, "conflict");
      read_word(12'h010, "conflict_back");

      // Backpressure and response latency
      req_stall = 5; resp_lat = 3;
      read_word(12'h236, "stall");
      req_stall = 0; resp_lat = 0;

      // Write requests are ignored
      @(negedge clk); req_rw = 1'b1; req_addr = 12'h010; req_valid = 1'b1;
      #4;
      check("rw_ready", ready, 1'b0);
      check("rw_hit", hit, 1'b0);
      @(negedge clk); #4;
      check("rw_busy", busy_o, 1'b0);
      req_rw = 1'b0;

      // Flush in IDLE on a hitting address
      @(negedge clk); req_addr = 12'h010; flush_i = 1'b1;
      #4;
      check("flush_idle_ready", ready, 1'b0);
      check("flush_idle_hit", hit, 1'b0);
      @(negedge clk); flush_i = 1'b0; req_valid = 1'b0;
      model_clear();
      read_word(12'h010, "after_flush");

      // Flush during a refill: line completes on the bus but is not installed
      issued.delete();
      @(negedge clk); req_addr = 12'h300; req_valid = 1'b1;
      #4;
      check("flush_refill_first", ready, 1'b0);
      ride_refill("flush_refill", 1'b1);
      check_issued("flush_refill", 12'h300);
      @(negedge clk); req_valid = 1'b0; flush_i = 1'b0;
      model_clear();
      read_word(12'h300, "flush_refill_again");
      read_word(12'h010, "flush_refill_other");

      // Redirect during the 0x010 refill
      model_clear();
      @(negedge clk); flush_i = 1'b1; req_valid = 1'b0;
      @(negedge clk); flush_i = 1'b0;
      @(negedge clk); req_addr = 12'h010; req_valid = 1'b1;
      #4;
      check("redirect_first", ready, 1'b0);
      @(negedge clk); req_addr = 12'h020;
      ride_refill("redirect", 1'b0);
      model_install(12'h010);
      read_word(12'h020, "redirect_next");
      read_word(12'h010, "redirect_installed");

      // Asynchronous reset in the middle of a refill; the late response must be ignored
      resp_lat = 3;
      @(negedge clk); req_addr = 12'h3C1; req_valid = 1'b1;
      cyc = 0;
      while (!pend && cyc < 50) begin @(negedge clk); cyc++; end
      check("rst_mid_pending", pend, 1'b1);
      #1 rst = 1'b1; req_valid = 1'b0;
      #1;
      check("rst_mid_busy", busy_o, 1'b0);
      check("rst_mid_mem_req", mem_req_valid, 1'b0);
      check("rst_mid_ready", ready, 1'b0);
      @(negedge clk); rst = 1'b0;
      repeat (8) @(negedge clk);
      check("rst_mid_idle", busy_o, 1'b0);
      resp_lat = 0;
      model_clear();
      read_word(12'h3C1, "rst_mid_refetch");
      read_word(12'h110, "rst_mid_cold");

      // Random fetches over a few conflicting sets with random bus timing
      for (int k = 0; k < 40; k++) begin
         req_stall = $urandom_range(0, 2);
         resp_lat  = $urandom_range(0, 2);
         ra = 12'(($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3));
         read_word(ra, "rand");
      end

      @(negedge clk); req_valid = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
